// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the async FIFO and its UART consumer.
// The FIFO side drives the head word and empty flag; the consumer returns the pop strobe.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  r_empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  rinc;

    modport master (
        output r_empty,
        output r_data,
        input  rinc
    );

    modport slave (
        input  r_empty,
        input  r_data,
        output rinc
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer that serialises each popped word as a UART frame,
// one bit per r_clk cycle: start, data LSB first, optional parity, stop.
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    fifo_uart_tx_if.slave        fifo,
    input  logic                 par_en_i,
    input  logic                 par_typ_i,
    output logic                 tx_out_o,
    output logic                 busy_o
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  load_w;

    // A pop is only legal from the last line bit or idle, which gives back-to-back frames
    assign load_w    = ((state_q == IDLE) || (state_q == STOP)) && !fifo.r_empty;
    assign fifo.rinc = load_w && !r_rst;
    assign tx_out_o  = tx_q;
    assign busy_o    = busy_q;

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // tx_d/busy_d describe the line during the state being entered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = shreg_q[0];
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = (^shreg_q) ^ par_typ_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    tx_d  = shreg_q[cnt_d];
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
                busy_d  = 1'b1;
            end
            STOP: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load_w) begin
            state_d   = START;
            shreg_d   = fifo.r_data;
            par_en_d  = par_en_i;
            par_typ_d = par_typ_i;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a word-queue FIFO model feeds the DUT and a
// bit-level scoreboard holds the expected line sequence for every pushed word.
module tb_fifo_uart_tx;
    localparam int DW = 8;

    typedef struct {
        logic tx;
        logic stop;
    } line_bit_t;

    logic r_clk = 1'b0;
    logic r_rst;
    logic par_en, par_typ;
    logic tx_out, busy;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) fifo_if ();

    fifo_uart_tx #(.DATA_WIDTH(DW)) dut (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .fifo      (fifo_if),
        .par_en_i  (par_en),
        .par_typ_i (par_typ),
        .tx_out_o  (tx_out),
        .busy_o    (busy)
    );

    always #5 r_clk = ~r_clk;

    logic [DW-1:0] wq[$];
    line_bit_t     exp_q[$];
    int checks = 0;
    int failures = 0;
    int rinc_cnt = 0;
    int busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh_fifo();
        fifo_if.r_empty = (wq.size() == 0);
        fifo_if.r_data  = (wq.size() != 0) ? wq[0] : '0;
    endfunction

    task automatic push_word(input logic [DW-1:0] w, input logic pe, input logic pt);
        line_bit_t b;
        wq.push_back(w);
        refresh_fifo();
        b.stop = 1'b0;
        b.tx = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < DW; i++) begin
            b.tx = w[i];
            exp_q.push_back(b);
        end
        if (pe) begin
            b.tx = (^w) ^ pt;
            exp_q.push_back(b);
        end
        b.tx = 1'b1;
        b.stop = 1'b1;
        exp_q.push_back(b);
    endtask

    // Each iteration ends at posedge+1; rinc is sampled before the edge it takes effect on
    task automatic run_cycles(input int n, input string tag);
        logic pre_rinc;
        line_bit_t cur;
        logic exp_tx, exp_busy, idle_or_stop, exp_rinc;
        for (int i = 0; i < n; i++) begin
            @(negedge r_clk);
            pre_rinc = fifo_if.rinc;
            @(posedge r_clk);
            #1;
            if (pre_rinc === 1'b1) begin
                rinc_cnt++;
                if (wq.size() != 0) void'(wq.pop_front());
                refresh_fifo();
            end
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                exp_tx = cur.tx;
                exp_busy = 1'b1;
                idle_or_stop = cur.stop;
            end else begin
                exp_tx = 1'b1;
                exp_busy = 1'b0;
                idle_or_stop = 1'b1;
            end
            exp_rinc = idle_or_stop && (wq.size() != 0);
            if (busy === 1'b1) busy_cnt++;
            check({tag, "_tx"}, 32'(tx_out), 32'(exp_tx));
            check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
            check({tag, "_rinc"}, 32'(fifo_if.rinc), 32'(exp_rinc));
        end
    endtask

    initial begin
        r_rst = 1'b1;
        par_en = 1'b0;
        par_typ = 1'b0;
        refresh_fifo();
        #12;
        check("rst_tx", 32'(tx_out), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rinc", 32'(fifo_if.rinc), 32'h0);
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;

        // Empty FIFO: line stays idle
        rinc_cnt = 0;
        run_cycles(50, "empty");
        check("empty_rinc_cnt", 32'(rinc_cnt), 32'd0);

        // Single A5, no parity
        rinc_cnt = 0;
        busy_cnt = 0;
        push_word(8'hA5, 1'b0, 1'b0);
        run_cycles(12, "a5");
        check("a5_rinc_cnt", 32'(rinc_cnt), 32'd1);
        check("a5_len", 32'(busy_cnt), 32'd10);

        // A5 with even then odd parity
        par_en = 1'b1;
        par_typ = 1'b0;
        busy_cnt = 0;
        push_word(8'hA5, 1'b1, 1'b0);
        run_cycles(13, "a5_even");
        check("a5_even_len", 32'(busy_cnt), 32'd11);
        par_typ = 1'b1;
        busy_cnt = 0;
        push_word(8'hA5, 1'b1, 1'b1);
        run_cycles(13, "a5_odd");
        check("a5_odd_len", 32'(busy_cnt), 32'd11);

        // Three queued words go out back-to-back
        par_en = 1'b0;
        par_typ = 1'b0;
        rinc_cnt = 0;
        busy_cnt = 0;
        push_word(8'h01, 1'b0, 1'b0);
        push_word(8'hFF, 1'b0, 1'b0);
        push_word(8'h80, 1'b0, 1'b0);
        run_cycles(33, "b2b");
        check("b2b_rinc_cnt", 32'(rinc_cnt), 32'd3);
        check("b2b_busy_cnt", 32'(busy_cnt), 32'd30);

        // Config flipped mid-frame only affects the following frame
        par_en = 1'b1;
        par_typ = 1'b0;
        push_word(8'hA5, 1'b1, 1'b0);
        run_cycles(4, "cfg1");
        par_en = 1'b0;
        par_typ = 1'b1;
        push_word(8'h3C, 1'b0, 1'b1);
        run_cycles(24, "cfg2");
        par_en = 1'b1;
        par_typ = 1'b1;
        push_word(8'h3C, 1'b1, 1'b1);
        run_cycles(13, "cfg3");

        // Async reset in the middle of the data field
        par_en = 1'b0;
        par_typ = 1'b0;
        push_word(8'hA5, 1'b0, 1'b0);
        run_cycles(5, "pre_rst");
        #3;
        r_rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx_out), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_rinc", 32'(fifo_if.rinc), 32'h0);
        exp_q.delete();
        @(posedge r_clk);
        #1;
        check("rsthold_tx", 32'(tx_out), 32'h1);
        check("fifo_after_rst", 32'(wq.size()), 32'd0);
        r_rst = 1'b0;

        // Recovery after reset
        rinc_cnt = 0;
        push_word(8'h5A, 1'b0, 1'b0);
        run_cycles(12, "recover");
        check("recover_rinc_cnt", 32'(rinc_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
